// File: rtl/isp_color_pkg.sv
// Shared fixed-point formats and colour-conversion constants for the ISP colour stages.
// Coefficients are packed row-major (R, G, B), and within each row the order is (Y, Cb, Cr).
package isp_color_pkg;

    localparam int COEF_W    = 18;
    localparam int COEF_FRAC = 16;
    localparam int PIX_FRAC  = 9;
    localparam int PROD_W    = 36;
    localparam int SUM_W     = 38;

    typedef logic signed [COEF_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;

    localparam logic [9*COEF_W-1:0] YCC2RGB_COEF = {
        18'sd65536,  18'sd0,      18'sd91882,
        18'sd65536, -18'sd22554, -18'sd46802,
        18'sd65536,  18'sd116130, 18'sd0
    };

    // Index 0 is the R/Y coefficient and index 8 is the B/Cr coefficient.
    function automatic sample_t coefAt(input int idx);
        return YCC2RGB_COEF[(8-idx)*COEF_W +: COEF_W];
    endfunction

endpackage

// File: rtl/ycc2rgb_if.sv
// Sample and pixel bus for ycc2rgb: Q9.9 Y/Cb/Cr in, packed RGB888 out.
interface ycc2rgb_if;
    logic               iValid;
    logic signed [17:0] iY;
    logic signed [17:0] iCb;
    logic signed [17:0] iCr;
    logic [23:0]        oData;
    logic               oValid;
    logic               oDone;

    modport master (output iValid, iY, iCb, iCr, input  oData, oValid, oDone);
    modport slave  (input  iValid, iY, iCb, iCr, output oData, oValid, oDone);
endinterface

// File: rtl/ycc_clamp8.sv
// Converts a Q13.25 channel sum to an unsigned 8-bit pixel by rounding it and then saturating it.
// Define YCC2RGB_ROUND_EN to select round-half-up. Leave it undefined to select floor truncation.
module ycc_clamp8
    import isp_color_pkg::*;
(
    input  sum_t       sum,
    output logic [7:0] pix
);
    logic signed [13:0] intPart;
    logic               unusedLsbs;

`ifdef YCC2RGB_ROUND_EN
    assign intPart = $signed({sum[37], sum[37:25]}) + $signed({13'd0, sum[24]});
`else
    assign intPart = $signed({sum[37], sum[37:25]});
`endif

    assign unusedLsbs = ^sum[24:0];

    always_comb begin
        pix = intPart[7:0];
        if (intPart < 0) begin
            pix = 8'd0;
        end else if (intPart > 14'sd255) begin
            pix = 8'd255;
        end
    end
endmodule

// File: rtl/ycc2rgb.sv
// YCbCr (Q9.9) to RGB888 converter: a 4-stage pipeline that ends in a per-frame done pulse.
// The rounding mode is selected inside ycc_clamp8 by YCC2RGB_ROUND_EN.
module ycc2rgb
    import isp_color_pkg::*;
#(
    parameter int width     = 320,
    parameter int height    = 240,
    parameter int frameSize = width * height
)(
    input  logic      clk,
    input  logic      reset,
    ycc2rgb_if.slave  bus
);
    localparam logic [16:0] FRAME_LAST = 17'(frameSize - 1);

    sample_t     pixReg   [3];
    logic        s1Valid;
    prod_t       prodNext [9];
    prod_t       prodReg  [9];
    logic        s2Valid;
    sum_t        sumNext  [3];
    sum_t        sumReg   [3];
    logic        s3Valid;
    logic [7:0]  chanPix  [3];
    logic [23:0] dataReg;
    logic        validReg;
    logic        doneReg;
    logic [16:0] pixCount;

    // S1: register the input sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid <= 1'b0;
            for (int i = 0; i < 3; i++) pixReg[i] <= '0;
        end else begin
            s1Valid   <= bus.iValid;
            pixReg[0] <= bus.iY;
            pixReg[1] <= bus.iCb;
            pixReg[2] <= bus.iCr;
        end
    end

    // S2: compute the nine constant-coefficient products. Row gi/3 is the channel and column gi%3 is the component.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : gProd
            localparam sample_t COEF = coefAt(gi);
            assign prodNext[gi] = PROD_W'(COEF) * PROD_W'(pixReg[gi % 3]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2Valid <= 1'b0;
            for (int i = 0; i < 9; i++) prodReg[i] <= '0;
        end else begin
            s2Valid <= s1Valid;
            for (int i = 0; i < 9; i++) prodReg[i] <= prodNext[i];
        end
    end

    // S3: form the per-channel sums. Three sign-extended products cannot overflow 38 bits.
    generate
        for (gi = 0; gi < 3; gi++) begin : gSum
            assign sumNext[gi] = SUM_W'(prodReg[3*gi]) + SUM_W'(prodReg[3*gi+1])
                               + SUM_W'(prodReg[3*gi+2]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s3Valid <= 1'b0;
            for (int i = 0; i < 3; i++) sumReg[i] <= '0;
        end else begin
            s3Valid <= s2Valid;
            for (int i = 0; i < 3; i++) sumReg[i] <= sumNext[i];
        end
    end

    // S4: round and clamp each channel, then register the packed pixel
    generate
        for (gi = 0; gi < 3; gi++) begin : gClamp
            ycc_clamp8 uClamp (
                .sum (sumReg[gi]),
                .pix (chanPix[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataReg  <= '0;
            validReg <= 1'b0;
            doneReg  <= 1'b0;
            pixCount <= '0;
        end else begin
            validReg <= s3Valid;
            doneReg  <= 1'b0;
            if (s3Valid) begin
                dataReg <= {chanPix[0], chanPix[1], chanPix[2]};
                if (pixCount == FRAME_LAST) begin
                    doneReg  <= 1'b1;
                    pixCount <= '0;
                end else begin
                    pixCount <= pixCount + 17'd1;
                end
            end
        end
    end

    assign bus.oData  = dataReg;
    assign bus.oValid = validReg;
    assign bus.oDone  = doneReg;
endmodule

// File: doc/ycc2rgb.md
Name: ycc2rgb

Overview:
Inverse of the forward colour-space stage. Converts signed fixed-point Y/Cb/Cr samples, as produced by the RGB-to-YCbCr stage, back to packed 8-bit RGB for display and output.
The datapath is a fixed-coefficient 3x3 multiply, then round and clamp, in a 4-stage pipeline. A per-frame pixel counter raises a done pulse after the last pixel of each frame.

Parameters:
width, 320, frame width in pixels
height, 240, frame height in pixels
frameSize, width*height, output pixels per frame; sets when oDone fires

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; clears all state
iValid  in  1  input sample valid; no back-pressure
iY  in  18  signed luma, 9 integer + 9 fractional bits (Q9.9)
iCb  in  18  signed Cb, Q9.9, zero-centred (no +128 offset)
iCr  in  18  signed Cr, Q9.9, zero-centred
oData  out  24  {R[23:16], G[15:8], B[7:0]}, unsigned 8-bit each
oValid  out  1  oData valid
oDone  out  1  one-cycle pulse on the cycle the frameSize-th pixel is output

Behaviour:
- Reset (reset=0, async): oData=0, oValid=0, oDone=0; all pipeline valids and the pixel counter are cleared. Takes effect immediately, including mid-frame; any in-flight pixels are discarded.
- Coefficients are 18-bit signed Q2.16 constants:
  - R = Y + 1.402*Cr, coefficients {65536, 0, 91882}
  - G = Y - 0.34414*Cb - 0.71414*Cr, coefficients {65536, -22554, -46802}
  - B = Y + 1.772*Cb, coefficients {65536, 116130, 0}
- Pipeline stages, fixed latency 4 cycles from iValid to oValid:
  - S1: register iY/iCb/iCr and iValid.
  - S2: nine 18x18 signed products, 36-bit, Q11.25.
  - S3: per-channel sum of three products, sign-extended to 38 bits.
  - S4: round, clamp, register oData/oValid.
- Round/clamp in S4:
  - Integer part is sum[37:25]; rounding adds sum[24] (round-half-up).
  - Result < 0 -> 0; result > 255 -> 255; otherwise result[7:0].
- iValid may be asserted every cycle or with arbitrary gaps; each valid propagates independently.
- When iValid=0, the datapath may still toggle, but oValid=0 and oData holds its last value.
- Pixel counter: 17-bit, increments on each oValid.
  - On the oValid where count==frameSize-1, oDone=1 on that same cycle and the counter returns to 0.
  - The next frame starts immediately; no idle cycle is required.
- oDone is never asserted without oValid.
- Input after the done pulse belongs to the next frame; there is no lockout.

Optional Feature:
YCC2RGB_ROUND_EN
- Defined: round-half-up as described above (adds sum[24]).
- Undefined: truncation toward negative infinity (sum[37:25] used directly), which saves one adder per channel.
- Clamp behaviour and latency are identical in both modes.

Decomposition:
- Package isp_color_pkg holds:
  - localparams COEF_W=18, COEF_FRAC=16, PIX_FRAC=9, PROD_W=36, SUM_W=38
  - the nine ycc2rgb coefficient constants as one packed 9*18 localparam, row-major R, G, B
- Sub-module ycc_clamp8: combinational round + saturate, 38-bit sum in, 8-bit out, honours YCC2RGB_ROUND_EN. Instantiated three times in S4.

Test Plan:
1. iY=65536 (128.0), iCb=0, iCr=0, one valid -> 4 cycles later oValid=1, oData=24'h808080, oDone=0.
2. iY=130560 (255.0), iCb=0, iCr=65280 (127.5) -> R clamps to 255. With ROUND_EN: oData=24'hFFA4FF (G=164). Without: 24'hFFA3FF (G=163).
3. iY=0, iCb=-65536 (-128.0), iCr=0 -> B negative clamps to 0, G=44 (0x2C) rounded / 44 truncated. oData=24'h002C00 (R=0).
4. frameSize=4 override; 4 valid inputs with 1-3 idle cycles between them -> oDone high only on the 4th oValid. A 5th input gives oValid with oDone=0 (counter wrapped).
5. frameSize=4; 2 pixels accepted, then reset pulsed low while pixels are in flight -> oValid/oData go to 0 immediately and no stale oValid appears. The next 4 pixels are needed to produce oDone.
6. Back-to-back iValid for 8 cycles with a ramp Y=0..7.0, Cb=Cr=0 -> 8 consecutive oValid starting at cycle 4 with gray values 0..7, in order, no gaps.
